// File: rtl/earth_pkg.sv
// -----------------------------------------------------------------------------
// earth_pkg
// Shared constants for the FP16 x INT4 multiplier sharing logic.
//   FP16_W        : width of an FP16 operand/result
//   INT4_W        : width of a signed INT4 operand
//   DEF_NUM_REQ   : default number of requesters sharing the multiplier
//   DEF_MAX_OUTST : default number of operations allowed in flight
// -----------------------------------------------------------------------------
package earth_pkg;

    localparam int FP16_W        = 16;
    localparam int INT4_W        = 4;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_OUTST = 4;

endpackage : earth_pkg

// File: rtl/fp16_int4_mul_arb_tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
// In-order FIFO of requester IDs, one entry per operation in flight.
// The head is presented combinationally so the return path can steer the
// current multiplier result without an extra cycle.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset (clears pointers)
//   push, push_data  : write one ID (ignored while full)
//   pop              : drop the head entry (ignored while empty)
//   head             : current head entry
//   full, empty      : occupancy flags
//   count            : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module tag_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointers wrap at DEPTH explicitly so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem_q[rd_q];

    // A push while full is refused even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = ptr_inc(wr_q);
        if (do_pop)  rd_d = ptr_inc(rd_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule : tag_fifo

// File: rtl/fp16_int4_mul_arb.sv
// -----------------------------------------------------------------------------
// fp16_int4_mul_arb
// Shares one FP16 x INT4 multiplier pipeline between NUM_REQ requesters.
// Issue side: round-robin arbiter with a grant lock that holds the selected
// requester while the multiplier stalls an offered operation. Every issued
// operation records its requester ID in an in-order tag FIFO; results are
// steered back to the head-of-FIFO requester.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   req_valid/req_ready             : per-requester operand handshake
//   req_fp16/req_int4               : packed operands, requester i at slice i
//   mul_in_valid/ready/fp16/int4    : issue interface to the multiplier
//   mul_out_valid/ready/fp16        : result interface from the multiplier
//   rsp_valid/rsp_ready             : per-requester result handshake
//   rsp_fp16                        : result data, broadcast
//   busy                            : operations in flight
//   err_orphan                      : sticky, result arrived with no tag
// -----------------------------------------------------------------------------
module fp16_int4_mul_arb
    import earth_pkg::*;
#(
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int MAX_OUTST = DEF_MAX_OUTST,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [FP16_W*NUM_REQ-1:0]   req_fp16,
    input  logic [INT4_W*NUM_REQ-1:0]   req_int4,
    output logic                        mul_in_valid,
    input  logic                        mul_in_ready,
    output logic [FP16_W-1:0]           mul_in_fp16,
    output logic [INT4_W-1:0]           mul_in_int4,
    input  logic                        mul_out_valid,
    output logic                        mul_out_ready,
    input  logic [FP16_W-1:0]           mul_out_fp16,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [FP16_W-1:0]           rsp_fp16,
    output logic                        busy,
    output logic                        err_orphan
);

    localparam int              CNT_W     = $clog2(MAX_OUTST + 1);
    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W + 1)'(NUM_REQ);

    logic [ID_W-1:0]    rr_q, rr_d;
    logic               lock_q, lock_d;
    logic [ID_W-1:0]    lock_id_q, lock_id_d;
    logic               orphan_q, orphan_d;

    logic [ID_W-1:0]    rot_idx [NUM_REQ];
    logic               arb_found;
    logic [ID_W-1:0]    arb_gnt;
    logic [ID_W-1:0]    gnt;
    logic               gnt_valid;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               any_valid;
    logic               can_issue;
    logic               issue_hs;

    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ID_W-1:0]    head;
    logic [NUM_REQ-1:0] head_oh;
    logic               has_tag;
    logic               pop;

    // Search order: rot_idx[k] = (rr_q + k) mod NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [ID_W:0] sum;
        assign sum         = {1'b0, rr_q} + (ID_W + 1)'(gi);
        assign rot_idx[gi] = (sum >= NUM_REQ_X) ? ID_W'(sum - NUM_REQ_X) : ID_W'(sum);
    end

    always_comb begin
        arb_found = 1'b0;
        arb_gnt   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_found && req_valid[rot_idx[k]]) begin
                arb_found = 1'b1;
                arb_gnt   = rot_idx[k];
            end
        end
    end

    // An offered-but-stalled operation keeps its requester until accepted,
    // so the multiplier never sees operands change under mul_in_valid.
    assign gnt       = lock_q ? lock_id_q : arb_gnt;
    assign gnt_valid = rst_n & (lock_q | arb_found);
    assign gnt_oh    = NUM_REQ'(1) << gnt;
    assign any_valid = |req_valid;

    // Outputs are forced to the cleared state while reset is asserted.
    assign mul_in_valid = rst_n & any_valid & ~fifo_full;
    assign can_issue    = rst_n & mul_in_ready & ~fifo_full;
    assign issue_hs     = mul_in_valid & mul_in_ready;
    assign req_ready    = (can_issue & gnt_valid) ? gnt_oh : '0;
    assign mul_in_fp16  = gnt_valid ? req_fp16[gnt*FP16_W +: FP16_W] : '0;
    assign mul_in_int4  = gnt_valid ? req_int4[gnt*INT4_W +: INT4_W] : '0;

    always_comb begin
        rr_d      = rr_q;
        lock_d    = 1'b0;
        lock_id_d = lock_id_q;
        if (issue_hs) begin
            rr_d = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end else if (mul_in_valid) begin
            lock_d    = 1'b1;
            lock_id_d = gnt;
        end
    end

    // Return path: the head tag names the owner of the current result.
    assign has_tag       = rst_n & ~fifo_empty;
    assign head_oh       = NUM_REQ'(1) << head;
    assign rsp_valid     = (mul_out_valid & has_tag) ? head_oh : '0;
    assign mul_out_ready = has_tag & rsp_ready[head];
    assign rsp_fp16      = mul_out_fp16;
    assign pop           = mul_out_valid & mul_out_ready;
    assign busy          = rst_n & (fifo_count != '0);

    assign orphan_d   = orphan_q | (mul_out_valid & fifo_empty);
    assign err_orphan = orphan_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            orphan_q  <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            orphan_q  <= orphan_d;
        end
    end

    tag_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue_hs),
        .push_data (gnt),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule : fp16_int4_mul_arb

// File: tb/tb_fp16_int4_mul_arb.sv
// -----------------------------------------------------------------------------
// tb_fp16_int4_mul_arb
// Directed bench for the multiplier arbiter. The bench plays the multiplier
// (fixed 3-cycle latency stub with an exact small FP16 x INT4 model) and
// keeps a scoreboard of expected (owner, result) pairs in issue order.
// -----------------------------------------------------------------------------
module tb_fp16_int4_mul_arb;

    localparam int NR  = 4;
    localparam int MO  = 4;
    localparam int LAT = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [16*NR-1:0] req_fp16;
    logic [4*NR-1:0]  req_int4;
    logic             mul_in_valid;
    logic             mul_in_ready;
    logic [15:0]      mul_in_fp16;
    logic [3:0]       mul_in_int4;
    logic             mul_out_valid;
    logic             mul_out_ready;
    logic [15:0]      mul_out_fp16;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready;
    logic [15:0]      rsp_fp16;
    logic             busy;
    logic             err_orphan;

    always #5 clk = ~clk;

    fp16_int4_mul_arb #(.NUM_REQ(NR), .MAX_OUTST(MO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_fp16      (req_fp16),
        .req_int4      (req_int4),
        .mul_in_valid  (mul_in_valid),
        .mul_in_ready  (mul_in_ready),
        .mul_in_fp16   (mul_in_fp16),
        .mul_in_int4   (mul_in_int4),
        .mul_out_valid (mul_out_valid),
        .mul_out_ready (mul_out_ready),
        .mul_out_fp16  (mul_out_fp16),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_fp16      (rsp_fp16),
        .busy          (busy),
        .err_orphan    (err_orphan)
    );

    logic [15:0] fp_tab [NR] = '{16'h3C00, 16'h4000, 16'h3800, 16'h4400};
    logic [3:0]  i4_tab [NR] = '{4'h3, 4'hF, 4'h2, 4'hD};

    typedef struct { int id; logic [15:0] d; } sb_t;
    typedef struct { logic [15:0] f; logic [3:0] i; int due; } pipe_t;

    sb_t   sb[$];
    pipe_t pipe[$];

    int n_err    = 0;
    int n_checks = 0;
    int n_issue  = 0;
    int out_cnt  = 0;
    int rr_model = 0;
    int cyc      = 0;
    logic force_orphan = 1'b0;

    // Negedge snapshot used by the multiplier stub at the following edge.
    logic        rst_s = 1'b0;
    logic        hs_in_s = 1'b0, hs_out_s = 1'b0;
    logic [15:0] in_f_s = '0;
    logic [3:0]  in_i_s = '0;

    // Exact for normal inputs whose product fits the mantissa (bench operands).
    function automatic logic [15:0] mul_model(input logic [15:0] a, input logic [3:0] b);
        logic [3:0]  mag;
        logic [14:0] p;
        logic [4:0]  e;
        int          sh;
        if (b == 4'h0 || a[14:10] == 5'h0) return {a[15] ^ b[3], 15'h0};
        mag = b[3] ? (~b + 4'd1) : b;
        p   = 15'({1'b1, a[9:0]}) * 15'(mag);
        sh  = 0;
        for (int k = 1; k <= 3; k++) if (p[10+k]) sh = k;
        e = a[14:10] + 5'(sh);
        return {a[15] ^ b[3], e, 10'(p >> sh)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < 300) begin
            tick();
            #1;
            n++;
        end
        chk("idle_timeout", 32'(n >= 300), 32'd0);
    endtask

    // Monitor: scoreboard push on issue, pop/compare on response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            out_cnt  = 0;
            rr_model = 0;
            rst_s    = 1'b0;
            hs_in_s  = 1'b0;
            hs_out_s = 1'b0;
        end else begin
            rst_s    = 1'b1;
            hs_in_s  = mul_in_valid & mul_in_ready;
            in_f_s   = mul_in_fp16;
            in_i_s   = mul_in_int4;
            hs_out_s = mul_out_valid & mul_out_ready;
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (req_valid == '1 && mul_in_ready)
                        chk("rr_order", 32'(i), 32'(rr_model));
                    sb.push_back('{id: i, d: mul_model(fp_tab[i], i4_tab[i])});
                    n_issue++;
                    out_cnt++;
                    rr_model = (i + 1) % NR;
                end
            end
            if ((rsp_valid & rsp_ready) != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("rsp_owner", 32'(rsp_valid), 32'(1 << e.id));
                    chk("rsp_data", 32'(rsp_fp16), 32'(e.d));
                    out_cnt--;
                end
            end
        end
    end

    // Multiplier stub: fixed latency, shares the reset.
    always @(posedge clk) begin
        #1;
        if (!rst_s) begin
            pipe.delete();
        end else begin
            if (hs_out_s && pipe.size() > 0) void'(pipe.pop_front());
            if (hs_in_s) pipe.push_back('{f: in_f_s, i: in_i_s, due: cyc + LAT});
        end
        cyc++;
        mul_out_valid = force_orphan | (pipe.size() > 0 && pipe[0].due <= cyc);
        mul_out_fp16  = (pipe.size() > 0) ? mul_model(pipe[0].f, pipe[0].i) : 16'h0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mul_out_valid = 1'b0;
        mul_out_fp16  = '0;
        for (int i = 0; i < NR; i++) begin
            req_fp16[16*i +: 16] = fp_tab[i];
            req_int4[4*i +: 4]   = i4_tab[i];
        end
        rst_n        = 1'b0;
        req_valid    = '1;
        mul_in_ready = 1'b1;
        rsp_ready    = '1;

        // Reset: all outputs in the cleared state even with requests pending.
        tick(); tick(); #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_mul_in_valid", 32'(mul_in_valid), 32'h0);
        chk("rst_mul_out_ready", 32'(mul_out_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err_orphan", 32'(err_orphan), 32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single request from requester 0.
        req_valid = 4'b0001; #1;
        chk("single_req_ready", 32'(req_ready), 32'h1);
        chk("single_in_valid", 32'(mul_in_valid), 32'h1);
        chk("single_in_fp16", 32'(mul_in_fp16), 32'h3C00);
        chk("single_in_int4", 32'(mul_in_int4), 32'h3);
        chk("single_busy_pre", 32'(busy), 32'h0);
        tick();
        req_valid = '0; #1;
        chk("single_busy_issue", 32'(busy), 32'h1);
        n = 0;
        while (rsp_valid == '0 && n < 20) begin tick(); #1; n++; end
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_fp16", 32'(rsp_fp16), 32'h4200);
        tick(); #1;
        chk("single_busy_done", 32'(busy), 32'h0);

        // All four requesters continuously valid.
        req_valid = '1;
        n = n_issue;
        repeat (16) tick();
        req_valid = '0;
        chk("all4_issued", 32'(n_issue - n), 32'd16);
        wait_idle();

        // Backpressure on the response side.
        rsp_ready = '0;
        req_valid = '1;
        repeat (10) begin
            tick(); #1;
            if (out_cnt == MO) begin
                chk("bp_req_ready", 32'(req_ready), 32'h0);
                chk("bp_in_valid", 32'(mul_in_valid), 32'h0);
            end
        end
        chk("bp_saturate", 32'(out_cnt), 32'(MO));
        chk("bp_busy", 32'(busy), 32'h1);
        rsp_ready = '1;
        repeat (8) tick();
        req_valid = '0;
        wait_idle();

        // Grant lock: point RR at 2, then stall requester 1 and raise 2.
        req_valid = 4'b0010;
        tick();
        req_valid    = '0;
        mul_in_ready = 1'b0;
        tick();
        req_valid = 4'b0010; #1;
        chk("lock_in_valid", 32'(mul_in_valid), 32'h1);
        chk("lock_in_fp16", 32'(mul_in_fp16), 32'h4000);
        tick();
        req_valid = 4'b0110; #1;
        repeat (3) begin
            chk("lock_hold_fp16", 32'(mul_in_fp16), 32'h4000);
            chk("lock_hold_ready", 32'(req_ready), 32'h0);
            tick(); #1;
        end
        mul_in_ready = 1'b1; #1;
        chk("lock_release_ready", 32'(req_ready), 32'h2);
        tick(); #1;
        chk("lock_next_fp16", 32'(mul_in_fp16), 32'h3800);
        chk("lock_next_ready", 32'(req_ready), 32'h4);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        wait_idle();

        // Steady push+pop at three in flight, 20 ops (wraps the pointers).
        req_valid = '1;
        n = 0;
        begin
            int base;
            base = n_issue;
            while (n_issue - base < 20 && n < 100) begin tick(); n++; end
        end
        req_valid = '0;
        chk("pp_cycles", 32'(n), 32'd20);
        chk("pp_inflight", 32'(out_cnt), 32'd3);
        wait_idle();

        // Orphan result with an empty FIFO.
        force_orphan = 1'b1;
        tick(); #1;
        chk("orphan_out_ready", 32'(mul_out_ready), 32'h0);
        chk("orphan_rsp_valid", 32'(rsp_valid), 32'h0);
        tick(); #1;
        chk("orphan_set", 32'(err_orphan), 32'h1);
        force_orphan = 1'b0;
        tick(); tick(); #1;
        chk("orphan_sticky", 32'(err_orphan), 32'h1);

        // Reset pulse mid-traffic.
        req_valid = '1;
        repeat (5) tick();
        rst_n = 1'b0;
        tick(); #1;
        chk("rst2_err_orphan", 32'(err_orphan), 32'h0);
        chk("rst2_busy", 32'(busy), 32'h0);
        chk("rst2_req_ready", 32'(req_ready), 32'h0);
        chk("rst2_in_valid", 32'(mul_in_valid), 32'h0);
        rst_n = 1'b1; #1;
        chk("rst2_rr_zero", 32'(req_ready), 32'h1);
        repeat (6) tick();
        req_valid = '0;
        wait_idle();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_fp16_int4_mul_arb

// File: doc/fp16_int4_mul_arb.md
Name: fp16_int4_mul_arb

Overview:
- Shares one fp16_int4_mul pipeline between NUM_REQ independent requesters.
- Round-robin arbitration on the issue side.
- Records the requester ID of every issued operation in an in-order tag FIFO.
- Steers each multiplier result back to the requester that issued it. Sits between the PE-lane operand sources and the single shared multiplier instance.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: requester ID width, = clog2(NUM_REQ); derived, not overridden.
- MAX_OUTST, 4: tag FIFO depth, i.e. maximum operations in flight inside the multiplier. Must be >= 3.

Ports:
- clk  in  1  Clock.
- rst_n  in  1  Synchronous active-low reset.
- req_valid  in  NUM_REQ  Per-requester operand valid.
- req_ready  out  NUM_REQ  Per-requester operand accepted.
- req_fp16  in  16*NUM_REQ  Packed FP16 operands; requester i occupies [16i+15:16i].
- req_int4  in  4*NUM_REQ  Packed signed INT4 operands; requester i occupies [4i+3:4i].
- mul_in_valid  out  1  To multiplier in_valid.
- mul_in_ready  in  1  From multiplier in_ready.
- mul_in_fp16  out  16  Selected FP16 operand.
- mul_in_int4  out  4  Selected INT4 operand.
- mul_out_valid  in  1  From multiplier out_valid.
- mul_out_ready  out  1  To multiplier out_ready.
- mul_out_fp16  in  16  Multiplier result.
- rsp_valid  out  NUM_REQ  One-hot result valid for the owning requester.
- rsp_ready  in  NUM_REQ  Per-requester result accept.
- rsp_fp16  out  16  Result data, broadcast to all requesters.
- busy  out  1  High while the tag FIFO is non-empty.
- err_orphan  out  1  Sticky flag: multiplier produced a result while the tag FIFO was empty.

Behaviour:
- Reset (rst_n low at a clk edge):
  - RR pointer = 0.
  - Tag FIFO cleared (rd/wr pointers and count = 0).
  - err_orphan = 0.
  - Every combinational output follows the cleared state: req_ready = 0, mul_in_valid = 0, mul_out_ready = 0, rsp_valid = 0, busy = 0.
  - Reset mid-operation discards all in-flight tags. The multiplier shares rst_n, so no stale results survive.
- Issue path (combinational, zero latency):
  - can_issue = mul_in_ready & (count < MAX_OUTST).
  - Grant goes to the first requester with req_valid set, searching from RR pointer upward with wrap modulo NUM_REQ.
  - mul_in_valid = any(req_valid) & (count < MAX_OUTST).
  - mul_in_fp16/int4 = the granted requester's operands; all zero when there is no grant.
  - req_ready[g] = can_issue for the granted g only; all other bits 0.
- Issue handshake (mul_in_valid & mul_in_ready): push g into the tag FIFO; RR pointer <= (g+1) mod NUM_REQ. Without a handshake the RR pointer holds.
- Full rule: when count == MAX_OUTST, issue is blocked even if a pop happens in the same cycle (no bypass).
- Return path (combinational):
  - head = tag FIFO head.
  - rsp_valid[head] = mul_out_valid & (count != 0).
  - mul_out_ready = (count != 0) & rsp_ready[head].
  - rsp_fp16 = mul_out_fp16.
- Pop: on mul_out_valid & mul_out_ready, pop the tag FIFO.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: pointers wrap modulo MAX_OUTST; MAX_OUTST need not be a power of two.
- Orphan: mul_out_valid with count == 0 sets err_orphan. The result is not acknowledged (mul_out_ready = 0). err_orphan stays set until reset.
- Stability: requester-side operand stability under req_valid & !req_ready is the requester's obligation. The arbiter may change the grant while mul_in_valid is low, but once mul_in_valid is asserted and not yet accepted, the grant is held. Implement this with a lock register holding g until handshake.
- Ordering: results return in issue order. A requester with several operations in flight receives them in its own issue order.
- busy = (count != 0).

Decomposition:
- Shared package (earth_pkg) holds:
  - FP16_W = 16.
  - INT4_W = 4.
  - Default NUM_REQ and MAX_OUTST localparams.
- One natural sub-module: tag_fifo, a synchronous FIFO of ID_W-bit entries, depth MAX_OUTST, with push/pop/full/empty/count and sync active-low reset.
- RR arbiter and lock stay inline.

Test Plan:
- Single request: req0 fp16 = 0x3C00, int4 = 0x3.
  - Expect rsp_valid = 0001 and rsp_fp16 = 0x4200.
  - busy rises on the issue cycle and falls after the response handshake.
- All four requesters valid continuously, each with distinct operands, e.g. 0x4000 × 0xF gives 0xC000.
  - Grant order is 0,1,2,3,0… and every response is returned to its owner.
- Backpressure: hold rsp_ready[head] = 0 for 10 cycles while requests keep arriving.
  - Count saturates at MAX_OUTST (4) and req_ready stays 0.
  - After release, no op is lost or duplicated and order is preserved.
- Grant lock: raise req2 while mul_in_ready = 0 and the grant is held on req1.
  - mul_in_fp16 stays req1's value until handshake.
  - The grant then moves to req2.
- Simultaneous push and pop with count = 3: count stays 3 and both pointers advance. Run 20 ops to exercise wrap.
- Force mul_out_valid = 1 with an empty FIFO (multiplier stub).
  - err_orphan sets and mul_out_ready = 0.
  - Pulsing rst_n low for one cycle mid-traffic clears err_orphan, busy and the RR pointer to 0.
